// File: rtl/knap_pkg.sv
// Shared definitions for the brute-force knapsack sequencer: sizes,
// per-instance item coefficient tables and the controller state type.
package knap_pkg;

    localparam int N_ITEMS = 8;
    localparam int W       = 8;

    // Sum width that can hold N items of the largest W-bit coefficient without wrapping.
    function automatic int sum_width(input int n_items, input int coef_w);
        return coef_w + $clog2(n_items) + 1;
    endfunction

    localparam int SW = sum_width(N_ITEMS, W);

    // Index 0 is item A, index 7 is item H.
    localparam logic [W-1:0] ITEM_VALUE [N_ITEMS] =
        '{8'd4, 8'd8, 8'd0, 8'd20, 8'd10, 8'd12, 8'd18, 8'd14};
    localparam logic [W-1:0] ITEM_WEIGHT [N_ITEMS] =
        '{8'd28, 8'd8, 8'd27, 8'd18, 8'd27, 8'd28, 8'd6, 8'd1};
    localparam logic [W-1:0] ITEM_VOLUME [N_ITEMS] =
        '{8'd27, 8'd27, 8'd4, 8'd4, 8'd0, 8'd24, 8'd4, 8'd20};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/knap_eval.sv
// Combinational evaluator: masked sums of the item value, weight and volume
// tables for one subset vector. Holds no state; the controller registers the result.
module knap_eval
    import knap_pkg::*;
(
    input  logic [N_ITEMS-1:0] sel,
    output logic [SW-1:0]      sum_v,
    output logic [SW-1:0]      sum_w,
    output logic [SW-1:0]      sum_vol
);

    // Add each selected item's coefficients into the three running sums.
    always_comb begin
        sum_v   = {SW{1'b0}};
        sum_w   = {SW{1'b0}};
        sum_vol = {SW{1'b0}};
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel[i]) begin
                sum_v   = sum_v   + {{(SW-W){1'b0}}, ITEM_VALUE[i]};
                sum_w   = sum_w   + {{(SW-W){1'b0}}, ITEM_WEIGHT[i]};
                sum_vol = sum_vol + {{(SW-W){1'b0}}, ITEM_VOLUME[i]};
            end else begin
                sum_v   = sum_v;
                sum_w   = sum_w;
                sum_vol = sum_vol;
            end
        end
    end

endmodule

// File: rtl/knap_enum_ctrl.sv
// Brute-force knapsack sequencer: enumerates every subset, evaluates it in a
// registered stage, qualifies it against latched limits and keeps the best one.
module knap_enum_ctrl
    import knap_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [W-1:0]       min_value,
    input  logic [W-1:0]       max_weight,
    input  logic [W-1:0]       max_volume,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [N_ITEMS-1:0] best_sel,
    output logic [SW-1:0]      best_value,
    output logic [N_ITEMS:0]   valid_count
);

    state_t               state_r;
    logic [N_ITEMS-1:0]   cand_r;
    logic                 drain_cnt_r;
    logic [W-1:0]         min_value_r;
    logic [W-1:0]         max_weight_r;
    logic [W-1:0]         max_volume_r;

    logic [SW-1:0]        eval_v_s;
    logic [SW-1:0]        eval_w_s;
    logic [SW-1:0]        eval_vol_s;

    logic                 e_valid_r;
    logic [N_ITEMS-1:0]   e_cand_r;
    logic [SW-1:0]        e_sum_v_r;
    logic [SW-1:0]        e_sum_w_r;
    logic [SW-1:0]        e_sum_vol_r;

    logic                 run_any_r;
    logic [N_ITEMS-1:0]   run_sel_r;
    logic [SW-1:0]        run_val_r;
    logic [N_ITEMS:0]     run_cnt_r;

    logic                 ok_s;
    logic                 run_any_s;
    logic [N_ITEMS-1:0]   run_sel_s;
    logic [SW-1:0]        run_val_s;
    logic [N_ITEMS:0]     run_cnt_s;

    logic                 busy_r;
    logic                 done_r;
    logic                 found_r;
    logic [N_ITEMS-1:0]   best_sel_r;
    logic [SW-1:0]        best_value_r;
    logic [N_ITEMS:0]     valid_count_r;

    knap_eval u_eval (
        .sel     (cand_r),
        .sum_v   (eval_v_s),
        .sum_w   (eval_w_s),
        .sum_vol (eval_vol_s)
    );

    // Stage E: register the sums of the candidate issued this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_r   <= 1'b0;
            e_cand_r    <= {N_ITEMS{1'b0}};
            e_sum_v_r   <= {SW{1'b0}};
            e_sum_w_r   <= {SW{1'b0}};
            e_sum_vol_r <= {SW{1'b0}};
        end else begin
            e_valid_r   <= (state_r == ST_RUN);
            e_cand_r    <= cand_r;
            e_sum_v_r   <= eval_v_s;
            e_sum_w_r   <= eval_w_s;
            e_sum_vol_r <= eval_vol_s;
        end
    end

    assign ok_s = (e_sum_v_r   >= {{(SW-W){1'b0}}, min_value_r})  &&
                  (e_sum_w_r   <= {{(SW-W){1'b0}}, max_weight_r}) &&
                  (e_sum_vol_r <= {{(SW-W){1'b0}}, max_volume_r});

    // Stage U: next running count/best; strict '>' keeps the earlier (smaller) subset on ties.
    always_comb begin
        run_any_s = run_any_r;
        run_sel_s = run_sel_r;
        run_val_s = run_val_r;
        run_cnt_s = run_cnt_r;
        if (e_valid_r && ok_s) begin
            run_cnt_s = run_cnt_r + {{N_ITEMS{1'b0}}, 1'b1};
            if (!run_any_r || (e_sum_v_r > run_val_r)) begin
                run_any_s = 1'b1;
                run_sel_s = e_cand_r;
                run_val_s = e_sum_v_r;
            end else begin
                run_any_s = run_any_r;
            end
        end else begin
            run_cnt_s = run_cnt_r;
        end
    end

    // Sequencer FSM with running accumulators and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cand_r        <= {N_ITEMS{1'b0}};
            drain_cnt_r   <= 1'b0;
            min_value_r   <= {W{1'b0}};
            max_weight_r  <= {W{1'b0}};
            max_volume_r  <= {W{1'b0}};
            run_any_r     <= 1'b0;
            run_sel_r     <= {N_ITEMS{1'b0}};
            run_val_r     <= {SW{1'b0}};
            run_cnt_r     <= {(N_ITEMS+1){1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            found_r       <= 1'b0;
            best_sel_r    <= {N_ITEMS{1'b0}};
            best_value_r  <= {SW{1'b0}};
            valid_count_r <= {(N_ITEMS+1){1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        min_value_r  <= min_value;
                        max_weight_r <= max_weight;
                        max_volume_r <= max_volume;
                        cand_r       <= {N_ITEMS{1'b0}};
                        run_any_r    <= 1'b0;
                        run_sel_r    <= {N_ITEMS{1'b0}};
                        run_val_r    <= {SW{1'b0}};
                        run_cnt_r    <= {(N_ITEMS+1){1'b0}};
                        busy_r       <= 1'b1;
                        state_r      <= ST_RUN;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        run_any_r <= run_any_s;
                        run_sel_r <= run_sel_s;
                        run_val_r <= run_val_s;
                        run_cnt_r <= run_cnt_s;
                        cand_r    <= cand_r + {{(N_ITEMS-1){1'b0}}, 1'b1};
                        if (cand_r == {N_ITEMS{1'b1}}) begin
                            drain_cnt_r <= 1'b0;
                            state_r     <= ST_DRAIN;
                        end else begin
                            state_r     <= ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        run_any_r <= run_any_s;
                        run_sel_r <= run_sel_s;
                        run_val_r <= run_val_s;
                        run_cnt_r <= run_cnt_s;
                        if (drain_cnt_r) begin
                            state_r     <= ST_DONE;
                        end else begin
                            drain_cnt_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_r        <= 1'b1;
                    busy_r        <= 1'b0;
                    found_r       <= run_any_r;
                    best_sel_r    <= run_any_r ? run_sel_r : {N_ITEMS{1'b0}};
                    best_value_r  <= run_any_r ? run_val_r : {SW{1'b0}};
                    valid_count_r <= run_cnt_r;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign found       = found_r;
    assign best_sel    = best_sel_r;
    assign best_value  = best_value_r;
    assign valid_count = valid_count_r;

endmodule

// File: tb/tb_knap_enum_ctrl.sv
// Self-checking bench for knap_enum_ctrl: a subset-enumerating reference model
// with a run-length timer, a per-cycle compare process, and directed plus random runs.
module tb_knap_enum_ctrl;
    import knap_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [7:0]         min_value;
    logic [7:0]         max_weight;
    logic [7:0]         max_volume;
    logic               busy;
    logic               done;
    logic               found;
    logic [N_ITEMS-1:0] best_sel;
    logic [SW-1:0]      best_value;
    logic [N_ITEMS:0]   valid_count;

    int total = 0;
    int bad   = 0;

    int tv   [8] = '{4, 8, 0, 20, 10, 12, 18, 14};
    int tw   [8] = '{28, 8, 27, 18, 27, 28, 6, 1};
    int tvol [8] = '{27, 27, 4, 4, 0, 24, 4, 20};

    // Model state: outputs the DUT must show after each clock edge.
    bit         m_run;
    int         m_k;
    bit         m_done;
    bit         m_found;
    logic [7:0] m_sel;
    int         m_val;
    int         m_cnt;
    bit         p_found;
    logic [7:0] p_sel;
    int         p_val;
    int         p_cnt;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    knap_enum_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .min_value   (min_value),
        .max_weight  (max_weight),
        .max_volume  (max_volume),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .best_sel    (best_sel),
        .best_value  (best_value),
        .valid_count (valid_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Enumerate all 256 subsets in ascending order; first strictly-better value wins.
    function automatic void brute(input int mn, input int mw, input int mv,
                                  output bit f, output logic [7:0] s,
                                  output int v, output int c);
        f = 1'b0; s = 8'd0; v = 0; c = 0;
        for (int sub = 0; sub < 256; sub++) begin
            int sv = 0;
            int sw = 0;
            int so = 0;
            for (int i = 0; i < 8; i++) begin
                if (((sub >> i) & 1) == 1) begin
                    sv += tv[i]; sw += tw[i]; so += tvol[i];
                end
            end
            if (sv >= mn && sw <= mw && so <= mv) begin
                c++;
                if (!f || sv > v) begin
                    f = 1'b1; s = sub[7:0]; v = sv;
                end
            end
        end
    endfunction

    // Reference model: a run lasts 259 edges after the accepting edge; abort before that cancels it.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_run = 1'b0; m_k = 0; m_done = 1'b0;
            m_found = 1'b0; m_sel = 8'd0; m_val = 0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (m_run) begin
                m_k++;
                if (m_k == 259) begin
                    m_done = 1'b1; m_run = 1'b0;
                    m_found = p_found; m_sel = p_sel; m_val = p_val; m_cnt = p_cnt;
                end else if (abort) begin
                    m_run = 1'b0;
                end
            end else if (start) begin
                m_run = 1'b1; m_k = 0;
                brute(min_value, max_weight, max_volume, p_found, p_sel, p_val, p_cnt);
            end
        end
    end

    // Compare every output against the model on each falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("busy", busy, m_run);
            chk("done", done, m_done);
            chk("found", found, m_found);
            chk("best_sel", best_sel, m_sel);
            chk("best_value", best_value, m_val);
            chk("valid_count", valid_count, m_cnt);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int mn, input int mw, input int mv, input bit ab);
        min_value = mn[7:0]; max_weight = mw[7:0]; max_volume = mv[7:0];
        start = 1'b1; abort = ab;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int  lat;
        bit  ab;
        int  at;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        min_value = 8'd0; max_weight = 8'd0; max_volume = 8'd0;
        step(3);
        chk_en = 1'b1;
        chk("reset_busy", busy, 32'd0);
        chk("reset_found", found, 32'd0);
        chk("reset_count", valid_count, 32'd0);
        rst = 1'b0;
        step(2);

        // Test 1: single valid subset.
        pulse_start(70, 60, 60, 1'b0);
        wait_done(lat);
        chk("t1_latency", lat, 32'd259);
        chk("t1_found", found, 32'd1);
        chk("t1_sel", best_sel, 32'hDA);
        chk("t1_value", best_value, 32'd70);
        chk("t1_count", valid_count, 32'd1);
        step(2);

        // Test 2: everything valid; item C has value 0 so the tie keeps 8'hFB.
        pulse_start(0, 255, 255, 1'b0);
        wait_done(lat);
        chk("t2_latency", lat, 32'd259);
        chk("t2_count", valid_count, 32'd256);
        chk("t2_sel", best_sel, 32'hFB);
        chk("t2_value", best_value, 32'd86);

        // Test 3: nothing valid; abort together with start (start wins).
        pulse_start(90, 255, 255, 1'b1);
        wait_done(lat);
        chk("t3_latency", lat, 32'd259);
        chk("t3_found", found, 32'd0);
        chk("t3_sel", best_sel, 32'd0);
        chk("t3_value", best_value, 32'd0);
        chk("t3_count", valid_count, 32'd0);

        // Test 4: abort 50 cycles into a run keeps previous results.
        pulse_start(70, 60, 60, 1'b0);
        wait_done(lat);
        pulse_start(0, 255, 255, 1'b0);
        step(49);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t4_busy_drop", busy, 32'd0);
        step(300);
        chk("t4_sel", best_sel, 32'hDA);
        chk("t4_count", valid_count, 32'd1);

        // Test 5: start ignored while busy and in the DONE state; accepted right after.
        pulse_start(0, 255, 255, 1'b0);
        step(99);
        min_value = 8'd90; start = 1'b1;
        step(1);
        start = 1'b0;
        step(158);
        min_value = 8'd90; max_weight = 8'd0; max_volume = 8'd0; start = 1'b1;
        step(1);
        chk("t5_done", done, 32'd1);
        chk("t5_count", valid_count, 32'd256);
        min_value = 8'd70; max_weight = 8'd60; max_volume = 8'd60;
        step(1);
        start = 1'b0;
        wait_done(lat);
        chk("t5_latency", lat, 32'd259);
        chk("t5_sel", best_sel, 32'hDA);
        chk("t5_count2", valid_count, 32'd1);

        // Test 6: reset in the middle of a run, then a clean run.
        pulse_start(0, 255, 255, 1'b0);
        step(99);
        rst = 1'b1;
        step(1);
        chk("t6_busy", busy, 32'd0);
        chk("t6_found", found, 32'd0);
        chk("t6_sel", best_sel, 32'd0);
        chk("t6_count", valid_count, 32'd0);
        rst = 1'b0;
        step(1);
        pulse_start(70, 60, 60, 1'b0);
        wait_done(lat);
        chk("t6_latency", lat, 32'd259);
        chk("t6_sel2", best_sel, 32'hDA);
        chk("t6_value", best_value, 32'd70);

        // Random runs with occasional aborts anywhere in RUN/DRAIN.
        for (int r = 0; r < 6; r++) begin
            ab = ($urandom_range(0, 2) == 0);
            pulse_start($urandom_range(30, 90), $urandom_range(20, 255),
                        $urandom_range(20, 255), $urandom_range(0, 1) == 1);
            if (ab) begin
                at = $urandom_range(1, 258);
                if (at > 1) step(at - 1);
                abort = 1'b1;
                step(1);
                abort = 1'b0;
                chk("rnd_abort_busy", busy, 32'd0);
                step(3);
            end else begin
                wait_done(lat);
                chk("rnd_latency", lat, 32'd259);
            end
            step($urandom_range(1, 4));
        end

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
